// File: rtl/heater_power_scheduler_if.sv
// Signal bundle between the heater demand sources and the power scheduler.
// The master drives demand/enable/clear; the scheduler (slave) returns gate drive and status.
interface heater_power_scheduler_if #(
  parameter int unsigned N_HEATERS = 2
);
  logic [N_HEATERS-1:0] req;
  logic [N_HEATERS-1:0] chan_en;
  logic [N_HEATERS-1:0] fault_clear;
  logic [N_HEATERS-1:0] heater_out;
  logic [N_HEATERS-1:0] fault;
  logic                 slot_strobe;
  logic [3:0]           active_count;

  modport master (
    output req, chan_en, fault_clear,
    input  heater_out, fault, slot_strobe, active_count
  );

  modport slave (
    input  req, chan_en, fault_clear,
    output heater_out, fault, slot_strobe, active_count
  );
endinterface

// File: rtl/heater_power_scheduler.sv
// Time-sliced heater supply sharing: grants at most MAX_ON channels per slot in
// round-robin order, with a per-channel runaway watchdog and sticky fault.
module heater_power_scheduler #(
  parameter int unsigned N_HEATERS    = 2,
  parameter int unsigned MAX_ON       = 1,
  parameter int unsigned SLOT_CYCLES  = 50000,
  parameter int unsigned MAX_SLOTS_ON = 60000,
  parameter int unsigned SLOT_W       = 16,
  parameter int unsigned WD_W         = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  heater_power_scheduler_if.slave bus
);
  localparam int unsigned RR_W = (N_HEATERS > 1) ? $clog2(N_HEATERS) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [WD_W-1:0]   WD_MAX    = WD_W'(MAX_SLOTS_ON);
  localparam logic [WD_W-1:0]   WD_TRIP   = WD_W'(MAX_SLOTS_ON - 1);

  logic [SLOT_W-1:0]    slot_cnt;
  logic                 boundary;
  logic [RR_W-1:0]      rr;
  logic [RR_W-1:0]      rr_next;
  logic [RR_W-1:0]      scan_idx;
  int unsigned          scan_cnt;
  logic [N_HEATERS-1:0] heater_q;
  logic [N_HEATERS-1:0] fault_q;
  logic [N_HEATERS-1:0] elig;
  logic [N_HEATERS-1:0] trip;
  logic [N_HEATERS-1:0] grant;
  logic [N_HEATERS-1:0] drive_next;
  logic [N_HEATERS-1:0] fault_next;
  logic [WD_W-1:0]      wd      [N_HEATERS];
  logic [WD_W-1:0]      wd_next [N_HEATERS];
  logic                 strobe_q;
  logic [3:0]           count_q;
  logic [3:0]           count_next;

  assign boundary = (slot_cnt == SLOT_LAST);
  assign elig     = bus.req & bus.chan_en & ~fault_q;

  // heater_q can only rise at a boundary, so being set in the last cycle of a
  // slot means it was on for the whole slot.
  always_comb begin
    trip = '0;
    for (int unsigned i = 0; i < N_HEATERS; i++) begin
      wd_next[i] = wd[i];
      if (boundary) begin
        if (heater_q[i]) begin
          if (wd[i] != WD_MAX) wd_next[i] = wd[i] + WD_W'(1);
          if (wd[i] >= WD_TRIP) trip[i] = 1'b1;
        end else begin
          wd_next[i] = '0;
        end
      end
      if (bus.fault_clear[i] && !trip[i]) wd_next[i] = '0;
    end
  end

  assign fault_next = (fault_q & ~bus.fault_clear) | trip;

  always_comb begin
    grant    = '0;
    rr_next  = rr;
    scan_cnt = 0;
    scan_idx = '0;
    for (int unsigned k = 0; k < N_HEATERS; k++) begin
      scan_idx = RR_W'((32'(rr) + k) % N_HEATERS);
      if (elig[scan_idx] && !trip[scan_idx] && (scan_cnt < MAX_ON)) begin
        grant[scan_idx] = 1'b1;
        scan_cnt        = scan_cnt + 1;
        rr_next         = (32'(scan_idx) == N_HEATERS - 1) ? '0 : scan_idx + RR_W'(1);
      end
    end
  end

  assign drive_next = boundary ? grant : (heater_q & elig);

  always_comb begin
    count_next = '0;
    for (int unsigned i = 0; i < N_HEATERS; i++) begin
      count_next = count_next + 4'(drive_next[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt <= '0;
      rr       <= '0;
      heater_q <= '0;
      fault_q  <= '0;
      strobe_q <= 1'b0;
      count_q  <= '0;
      for (int unsigned i = 0; i < N_HEATERS; i++) wd[i] <= '0;
    end else begin
      slot_cnt <= boundary ? '0 : slot_cnt + SLOT_W'(1);
      if (boundary) rr <= rr_next;
      heater_q <= drive_next;
      fault_q  <= fault_next;
      strobe_q <= boundary;
      count_q  <= count_next;
      for (int unsigned i = 0; i < N_HEATERS; i++) wd[i] <= wd_next[i];
    end
  end

  assign bus.heater_out   = heater_q;
  assign bus.fault        = fault_q;
  assign bus.slot_strobe  = strobe_q;
  assign bus.active_count = count_q;
endmodule
